// File: rtl/glyph_rom_arbiter_pkg.sv
// glyph_rom_arbiter_pkg
//   Shared constants for the glyph ROM arbiter: requester count, ROM address
//   and data widths, ROM read latency. Also holds the small index helpers
//   used by the arbiter.
package glyph_rom_arbiter_pkg;

    localparam int GLYPH_N       = 4;   // block renderers sharing the ROM
    localparam int GLYPH_AW      = 10;  // glyph ROM address width
    localparam int GLYPH_DW      = 32;  // glyph ROM data width
    localparam int GLYPH_ROM_LAT = 1;   // ROM read latency, 1..4

    // Pointer width; a single requester still gets a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment modulo n with an explicit wrap, so n need not be a power of 2.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/glyph_rom_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches req starting at ptr and
//   wrapping modulo N; the first set bit wins.
// Ports:
//   req      in   N   request vector
//   ptr      in   PW  index with highest priority this cycle
//   win_oh   out  N   one-hot winner (zero when no request)
//   win_idx  out  PW  winner index (zero when no request)
//   win_any  out  1   at least one request present
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [PW-1:0] win_idx,
    output logic          win_any
);

    int            pos;
    logic [PW-1:0] idx;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        pos     = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) pos = pos - N;
            idx = PW'(pos);
            if (!win_any && req[idx]) begin
                win_any     = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/glyph_rom_arbiter.sv
// glyph_rom_arbiter
//   Shares one synchronous glyph ROM between N tile renderers. Grants one
//   requester per cycle in round-robin order, drives the ROM address, tracks
//   the ROM latency with a grant-tag shift register and loads the returned
//   word into the granted requester's response slot.
// Ports:
//   clk          in   1     system clock
//   rst          in   1     asynchronous active-high reset
//   req          in   N     per-requester request level
//   req_addr     in   N*AW  requester k address at [k*AW +: AW]
//   gnt          out  N     registered one-hot grant (or zero)
//   rom_address  out  AW    registered ROM address
//   rom_data     in   DW    ROM read data
//   rsp_valid    out  N     one-cycle pulse: slot k just loaded
//   rsp_data     out  N*DW  held response for requester k at [k*DW +: DW]
module glyph_rom_arbiter
    import glyph_rom_arbiter_pkg::*;
#(
    parameter int N       = GLYPH_N,
    parameter int AW      = GLYPH_AW,
    parameter int DW      = GLYPH_DW,
    parameter int ROM_LAT = GLYPH_ROM_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] req_addr,
    output logic [N-1:0]    gnt,
    output logic [AW-1:0]   rom_address,
    input  logic [DW-1:0]   rom_data,
    output logic [N-1:0]    rsp_valid,
    output logic [N*DW-1:0] rsp_data
);

    localparam int PW = ptr_width(N);

    logic [N-1:0][AW-1:0]      addr_arr;
    logic [N-1:0][DW-1:0]      rsp_q;
    logic [ROM_LAT-1:0][N-1:0] tag_pipe;
    logic [N-1:0]              tag_out;
    logic [PW-1:0]             ptr;
    logic [PW-1:0]             win_idx;
    logic [N-1:0]              win_oh;
    logic                      win_any;

    for (genvar k = 0; k < N; k++) begin : g_addr
        assign addr_arr[k] = req_addr[k*AW +: AW];
    end

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    // Arbitration: address and pointer only move on a real grant, so an
    // idle cycle leaves the ROM address parked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt         <= '0;
            rom_address <= '0;
            ptr         <= '0;
        end else if (win_any) begin
            gnt         <= win_oh;
            rom_address <= addr_arr[win_idx];
            ptr         <= PW'(wrap_inc(int'(win_idx), N));
        end else begin
            gnt         <= '0;
        end
    end

    // The grant tag follows its address through the ROM. gnt is visible the
    // cycle the ROM registers the address, so ROM_LAT stages line the tag up
    // with the cycle the data is valid on rom_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= gnt;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out = tag_pipe[ROM_LAT-1];

    // Capture: only the tagged slot is written; the others keep their word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_q     <= '0;
        end else begin
            rsp_valid <= tag_out;
            for (int k = 0; k < N; k++) begin
                if (tag_out[k]) rsp_q[k] <= rom_data;
            end
        end
    end

    assign rsp_data = rsp_q;

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// tb_glyph_rom_arbiter
//   Self-checking bench: a directed vector table from reset, a reset
//   mid-flight sequence, then randomized traffic against a queue-based
//   reference model of the arbiter and ROM.
module tb_glyph_rom_arbiter;
    import glyph_rom_arbiter_pkg::*;

    localparam int N   = GLYPH_N;
    localparam int AW  = GLYPH_AW;
    localparam int DW  = GLYPH_DW;
    localparam int LAT = GLYPH_ROM_LAT;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_address;
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    rsp_valid;
    logic [N*DW-1:0] rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    glyph_rom_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data)
    );

    // ROM contents
    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        if (a == 10'h02A) return 32'hDEADBEEF;
        return ({a, 22'h0} ^ (32'h9E3779B9 * {22'h0, a}) ^ 32'h1234_5678);
    endfunction

    // Synchronous ROM model with LAT clocks of read latency
    logic [DW-1:0] rom_q [LAT];
    always @(posedge clk) begin
        rom_q[0] <= rom_f(rom_address);
        for (int i = 1; i < LAT; i++) rom_q[i] <= rom_q[i-1];
    end
    assign rom_data = rom_q[LAT-1];

    task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] pack_data(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                                  input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            k;
        logic [DW-1:0] d;
    } pend_t;

    pend_t         pend[$];
    int            m_ptr;
    int            edge_no;
    logic [N-1:0]  m_gnt;
    logic [AW-1:0] m_ra;
    logic [N-1:0]  m_rv;
    logic [DW-1:0] m_data [N];

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        int w;
        int k;
        logic [AW-1:0] a;
        if (rst) begin
            m_ptr = 0; m_gnt = '0; m_ra = '0; m_rv = '0;
            for (int j = 0; j < N; j++) m_data[j] = '0;
            pend.delete();
        end else begin
            m_rv = '0;
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == edge_no) begin
                    m_rv[pend[i].k] = 1'b1;
                    m_data[pend[i].k] = pend[i].d;
                    pend.delete(i);
                end
            end
            w = -1;
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (w < 0 && req[k]) w = k;
            end
            if (w >= 0) begin
                a = req_addr[w*AW +: AW];
                m_gnt = '0;
                m_gnt[w] = 1'b1;
                m_ra = a;
                m_ptr = (w + 1) % N;
                pend.push_back('{due: edge_no + 1 + LAT, k: w, d: rom_f(a)});
            end else begin
                m_gnt = '0;
            end
        end
        edge_no++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  gnt;
        logic [AW-1:0] ra;
        logic [N-1:0]  rv;
    } vec_t;

    vec_t tbl [22];

    initial begin
        logic [N*DW-1:0] exp_d;

        tbl[0]  = '{4'b0100, 4'b0100, 10'h02A, 4'b0000};  // single requester
        tbl[1]  = '{4'b0000, 4'b0000, 10'h02A, 4'b0001};
        tbl[2]  = '{4'b0000, 4'b0000, 10'h02A, 4'b0100};  // t+3 response
        tbl[3]  = '{4'b0000, 4'b0000, 10'h02A, 4'b0000};
        tbl[4]  = '{4'b1111, 4'b1000, 10'h133, 4'b0000};  // all requesting, ptr=3
        tbl[5]  = '{4'b1111, 4'b0001, 10'h100, 4'b0000};
        tbl[6]  = '{4'b1111, 4'b0010, 10'h111, 4'b1000};
        tbl[7]  = '{4'b1111, 4'b0100, 10'h02A, 4'b0001};
        tbl[8]  = '{4'b1111, 4'b1000, 10'h133, 4'b0010};
        tbl[9]  = '{4'b1111, 4'b0001, 10'h100, 4'b0100};
        tbl[10] = '{4'b1111, 4'b0010, 10'h111, 4'b1000};
        tbl[11] = '{4'b1111, 4'b0100, 10'h02A, 4'b0001};
        tbl[12] = '{4'b0001, 4'b0001, 10'h100, 4'b0010};  // leaves ptr=1
        tbl[13] = '{4'b1001, 4'b1000, 10'h133, 4'b0100};  // pointer skip
        tbl[14] = '{4'b1001, 4'b0001, 10'h100, 4'b0001};
        tbl[15] = '{4'b0000, 4'b0000, 10'h100, 4'b1000};  // idle: address held
        tbl[16] = '{4'b0000, 4'b0000, 10'h100, 4'b0001};
        tbl[17] = '{4'b0100, 4'b0100, 10'h02A, 4'b0000};  // leaves ptr=3
        tbl[18] = '{4'b0011, 4'b0001, 10'h100, 4'b0000};  // req1 then withdrawn
        tbl[19] = '{4'b0000, 4'b0000, 10'h100, 4'b0100};
        tbl[20] = '{4'b0000, 4'b0000, 10'h100, 4'b0001};
        tbl[21] = '{4'b0000, 4'b0000, 10'h100, 4'b0000};

        req_addr = {10'h133, 10'h02A, 10'h111, 10'h100};

        // Reset held with all requesting
        rst = 1'b1;
        req = 4'b1111;
        #2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_gnt", gnt, '0);
            chk("reset_rsp_valid", rsp_valid, '0);
        end
        chk("reset_rom_address", rom_address, '0);
        chk("reset_rsp_data", rsp_data, '0);

        rst = 1'b0;
        tick();
        chk("first_gnt", gnt, 4'b0001);
        chk("first_rom_address", rom_address, 10'h100);

        for (int i = 0; i < 22; i++) begin
            req = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_rom_address", i), rom_address, tbl[i].ra);
            chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].rv);
            if (i == 3) begin
                exp_d = pack_data(rom_f(10'h100), '0, 32'hDEADBEEF, '0);
                chk("held_after_single", rsp_data, exp_d);
            end
        end
        exp_d = pack_data(rom_f(10'h100), rom_f(10'h111), 32'hDEADBEEF, rom_f(10'h133));
        chk("table_rsp_data", rsp_data, exp_d);

        // Reset mid-flight: grant, then reset before the data returns
        req = 4'b0010;
        tick();
        chk("midflight_gnt", gnt, 4'b0010);
        req = 4'b0000;
        rst = 1'b1;
        #1;
        chk("midflight_gnt_cleared", gnt, '0);
        chk("midflight_rsp_data", rsp_data, '0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("midflight_rsp_valid_in_rst", rsp_valid, '0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midflight_rsp_valid", rsp_valid, '0);
            chk("midflight_rsp_data_zero", rsp_data, '0);
        end
        req = 4'b1111;
        tick();
        chk("ptr_after_reset", gnt, 4'b0001);

        // Randomized traffic against the reference model
        req = '0;
        rst = 1'b1;
        edge_no = 0;
        model_step();
        tick();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            req = N'($urandom);
            if ($urandom_range(0, 3) == 0) req = '1;
            for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = AW'($urandom);
            model_step();
            tick();
            for (int k = 0; k < N; k++) exp_d[k*DW +: DW] = m_data[k];
            chk("rnd_gnt", gnt, m_gnt);
            chk("rnd_rom_address", rom_address, m_ra);
            chk("rnd_rsp_valid", rsp_valid, m_rv);
            chk("rnd_rsp_data", rsp_data, exp_d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
